fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle-ROM CPU datapath. Owns the program counter, drives the combinational instruction memory address, and registers each fetched word into a one-entry valid/ready output slot for the decode stage. Unconditional jumps (opcode 9) are resolved inside the block. Branches are resolved downstream and fed back through a redirect port. An all-zero word halts fetch.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory address and registers each fetched word into a one-entry valid/ready
// slot for decode. Unconditional jumps are resolved here; branch redirects
// arrive from downstream. An all-zero instruction word halts fetch.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter logic [5:0]  JUMP_OP = 6'd9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic                out_valid_q, out_valid_d;

  logic                slot_free;
  logic                word_zero;
  logic                word_jump;

  // Slot can take a new word when empty or when decode drains it this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign word_zero = (imem_data == '0);
  assign word_jump = (imem_data[DATA_W-1 -: 6] == JUMP_OP);

  // Next-state, PC and output-slot update logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        pc_d        = '0;
        out_valid_d = 1'b0;
        if (start) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (redirect_valid) begin
          // Redirect wins over everything; any held word is flushed.
          pc_d        = redirect_addr;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          if (word_zero) begin
            state_d     = StHalt;
            out_valid_d = 1'b0;
          end else if (word_jump) begin
            // Jump is consumed here and never forwarded; upper target bits dropped.
            pc_d        = imem_data[ADDR_W-1:0];
            out_valid_d = 1'b0;
          end else begin
            out_instr_d = imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
          end
        end
      end

      StHalt: begin
        out_valid_d = 1'b0;
        if (redirect_valid) begin
          state_d = StFetch;
          pc_d    = redirect_addr;
        end else if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      default: begin
        state_d     = StIdle;
        pc_d        = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and output-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == StHalt);
  assign busy      = (state_q == StFetch);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus a transfer scoreboard,
// followed by a hand-written asynchronous reset sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        halted;
  logic        busy;

  int total;
  int bad;

  logic [31:0] rom [32];
  assign imem_data = rom[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        rv;
    logic [4:0]  raddr;
    logic        xfer;    // slot is expected to transfer on this edge
    logic [4:0]  xpc;
    logic [31:0] xinstr;
    logic        ev;      // expected outputs after the edge
    logic [4:0]  epc;
    logic [31:0] einstr;
    logic [4:0]  eimem;
    logic        eh;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] instr;
  } xfer_t;

  localparam int NVEC = 28;
  vec_t  vec [NVEC];
  xfer_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake edge pops the next expected transfer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got pc %0d expected none", out_pc);
      end else begin
        xfer_t x;
        x = sb.pop_front();
        check("xfer_pc", 32'(out_pc), 32'(x.pc));
        check("xfer_instr", out_instr, x.instr);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h1C00_0000 | 32'(i);
    rom[0]  = 32'h180A_000A;
    rom[1]  = 32'h180F_000F;
    rom[5]  = 32'h2400_000C;
    rom[7]  = 32'h0000_0000;
    rom[10] = 32'h1804_0004;
    rom[12] = 32'h2085_0007;

    //        st rdy rv raddr xf xpc  xinstr          ev epc  einstr          eimem eh eb
    vec[0]  = '{1, 1, 0, 0,  0, 0,  32'h0,          0, 0,  32'h0,          0,  0, 1};
    vec[1]  = '{0, 1, 0, 0,  0, 0,  32'h0,          1, 0,  32'h180A000A,   1,  0, 1};
    vec[2]  = '{0, 1, 0, 0,  1, 0,  32'h180A000A,   1, 1,  32'h180F000F,   2,  0, 1};
    vec[3]  = '{0, 1, 0, 0,  1, 1,  32'h180F000F,   1, 2,  32'h1C000002,   3,  0, 1};
    vec[4]  = '{0, 0, 0, 0,  0, 0,  32'h0,          1, 2,  32'h1C000002,   3,  0, 1};
    vec[5]  = '{0, 0, 0, 0,  0, 0,  32'h0,          1, 2,  32'h1C000002,   3,  0, 1};
    vec[6]  = '{0, 0, 0, 0,  0, 0,  32'h0,          1, 2,  32'h1C000002,   3,  0, 1};
    vec[7]  = '{0, 1, 0, 0,  1, 2,  32'h1C000002,   1, 3,  32'h1C000003,   4,  0, 1};
    vec[8]  = '{0, 1, 0, 0,  1, 3,  32'h1C000003,   1, 4,  32'h1C000004,   5,  0, 1};
    vec[9]  = '{0, 1, 0, 0,  1, 4,  32'h1C000004,   0, 0,  32'h0,          12, 0, 1};
    vec[10] = '{0, 1, 0, 0,  0, 0,  32'h0,          1, 12, 32'h20850007,   13, 0, 1};
    vec[11] = '{0, 1, 0, 0,  1, 12, 32'h20850007,   1, 13, 32'h1C00000D,   14, 0, 1};
    vec[12] = '{0, 0, 1, 10, 0, 0,  32'h0,          0, 0,  32'h0,          10, 0, 1};
    vec[13] = '{0, 1, 0, 0,  0, 0,  32'h0,          1, 10, 32'h18040004,   11, 0, 1};
    vec[14] = '{0, 1, 1, 7,  1, 10, 32'h18040004,   0, 0,  32'h0,          7,  0, 1};
    vec[15] = '{0, 1, 0, 0,  0, 0,  32'h0,          0, 0,  32'h0,          7,  1, 0};
    vec[16] = '{0, 1, 0, 0,  0, 0,  32'h0,          0, 0,  32'h0,          7,  1, 0};
    vec[17] = '{1, 1, 0, 0,  0, 0,  32'h0,          0, 0,  32'h0,          0,  0, 1};
    vec[18] = '{0, 1, 0, 0,  0, 0,  32'h0,          1, 0,  32'h180A000A,   1,  0, 1};
    vec[19] = '{0, 1, 0, 0,  1, 0,  32'h180A000A,   1, 1,  32'h180F000F,   2,  0, 1};
    vec[20] = '{0, 1, 1, 30, 1, 1,  32'h180F000F,   0, 0,  32'h0,          30, 0, 1};
    vec[21] = '{0, 1, 0, 0,  0, 0,  32'h0,          1, 30, 32'h1C00001E,   31, 0, 1};
    vec[22] = '{0, 1, 0, 0,  1, 30, 32'h1C00001E,   1, 31, 32'h1C00001F,   0,  0, 1};
    vec[23] = '{0, 1, 0, 0,  1, 31, 32'h1C00001F,   1, 0,  32'h180A000A,   1,  0, 1};
    vec[24] = '{0, 1, 1, 7,  1, 0,  32'h180A000A,   0, 0,  32'h0,          7,  0, 1};
    vec[25] = '{0, 1, 0, 0,  0, 0,  32'h0,          0, 0,  32'h0,          7,  1, 0};
    vec[26] = '{1, 1, 1, 20, 0, 0,  32'h0,          0, 0,  32'h0,          20, 0, 1};
    vec[27] = '{0, 0, 0, 0,  0, 0,  32'h0,          1, 20, 32'h1C000014,   21, 0, 1};

    rst_n          = 1'b0;
    start          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      start          = vec[i].start;
      out_ready      = vec[i].ready;
      redirect_valid = vec[i].rv;
      redirect_addr  = vec[i].raddr;
      if (vec[i].xfer) sb.push_back('{pc: vec[i].xpc, instr: vec[i].xinstr});
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vec[i].ev));
      check($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vec[i].eimem));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vec[i].eh));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].eb));
      if (vec[i].ev) begin
        check($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(vec[i].epc));
        check($sformatf("v%0d_out_instr", i), out_instr, vec[i].einstr);
      end
    end
    start          = 1'b0;
    redirect_valid = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset between edges while a word sits stalled in the slot.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_out_pc", 32'(out_pc), 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    check("arst_imem_addr", 32'(imem_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_out_pc", 32'(out_pc), 32'd0);
    check("restart_out_instr", out_instr, 32'h180A000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
